// File: rtl/ro_puf_pair_comparator.sv
// RO-PUF response engine: per response bit, counts edges of one oscillator pair over a
// programmable window and compares them. Optional margin flags via macro ROPUF_MARGIN_EN.
module ro_puf_pair_comparator #(
  parameter int N_RO   = 16,
  parameter int SEL_W  = $clog2(N_RO),
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int RESP_W = 8
`ifdef ROPUF_MARGIN_EN
  ,
  parameter logic [CNT_W-1:0] MARGIN_TH = 4
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_RO-1:0]   ro_in,
  input  logic              start,
  input  logic [SEL_W-1:0]  chal_a,
  input  logic [SEL_W-1:0]  chal_b,
  input  logic [WIN_W-1:0]  win_len,
  output logic              ro_en,
  output logic              busy,
  output logic              done,
  output logic [RESP_W-1:0] response
`ifdef ROPUF_MARGIN_EN
  ,
  output logic [RESP_W-1:0] unstable_mask
`endif
);

  localparam int KW = (RESP_W > 1) ? $clog2(RESP_W) : 1;
  localparam logic [SEL_W:0]   N_RO_W   = (SEL_W+1)'(N_RO);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_RO - 1);
  localparam logic [KW-1:0]    LAST_BIT = KW'(RESP_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_COUNT, S_COMPARE, S_DONE} state_t;

  state_t              r_state;
  logic [WIN_W-1:0]    r_win;
  logic [WIN_W-1:0]    r_wcnt;
  logic [KW-1:0]       r_bit;
  logic [RESP_W-1:0]   r_resp;
  logic                r_busy;
  logic                r_ro_en;
  logic                r_done;
`ifdef ROPUF_MARGIN_EN
  logic [RESP_W-1:0]   r_unst;
  logic [CNT_W-1:0]    w_diff;
`endif

  logic [SEL_W-1:0]    w_chal [2];
  logic [SEL_W-1:0]    r_idx  [2];
  logic [2:0]          r_sync [2];
  logic [CNT_W-1:0]    r_cnt  [2];

  logic                w_accept;
  logic                w_clr;
  logic                w_counting;
  logic [WIN_W-1:0]    w_win;

  assign w_chal[0]  = chal_a;
  assign w_chal[1]  = chal_b;
  // start coinciding with the done pulse belongs to the finishing run and is dropped
  assign w_accept   = (r_state == S_IDLE) && start && !r_done;
  assign w_clr      = (r_state == S_IDLE) || (r_state == S_COMPARE);
  assign w_counting = (r_state == S_COUNT);
  assign w_win      = (win_len == '0) ? WIN_W'(1) : win_len;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [SEL_W:0]   w_ext;
      logic [SEL_W-1:0] w_base;
      logic             w_edge;

      // challenge may exceed N_RO-1 when N_RO is not a power of two; fold it once
      assign w_ext  = {1'b0, w_chal[gi]};
      assign w_base = (w_ext >= N_RO_W) ? SEL_W'(w_ext - N_RO_W) : w_chal[gi];
      assign w_edge = r_sync[gi][1] & ~r_sync[gi][2];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_idx[gi] <= '0;
        end else if (w_accept) begin
          r_idx[gi] <= w_base;
        end else if (r_state == S_COMPARE) begin
          r_idx[gi] <= (r_idx[gi] == LAST_IDX) ? '0 : r_idx[gi] + 1'b1;
        end
      end

      // sync[0..1] is the 2-FF synchroniser, sync[2] the previous value for edge detect
      always_ff @(posedge clk) begin
        if (rst || w_clr) begin
          r_sync[gi] <= '0;
          r_cnt[gi]  <= '0;
        end else begin
          r_sync[gi] <= {r_sync[gi][1:0], ro_in[r_idx[gi]]};
          if (w_counting && w_edge && !(&r_cnt[gi])) begin
            r_cnt[gi] <= r_cnt[gi] + 1'b1;
          end
        end
      end
    end
  endgenerate

`ifdef ROPUF_MARGIN_EN
  assign w_diff = (r_cnt[0] > r_cnt[1]) ? (r_cnt[0] - r_cnt[1]) : (r_cnt[1] - r_cnt[0]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_win   <= '0;
      r_wcnt  <= '0;
      r_bit   <= '0;
      r_resp  <= '0;
      r_busy  <= 1'b0;
      r_ro_en <= 1'b0;
      r_done  <= 1'b0;
`ifdef ROPUF_MARGIN_EN
      r_unst  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state <= S_SETTLE;
            r_win   <= w_win;
            r_wcnt  <= '0;
            r_bit   <= '0;
            r_resp  <= '0;
            r_busy  <= 1'b1;
            r_ro_en <= 1'b1;
`ifdef ROPUF_MARGIN_EN
            r_unst  <= '0;
`endif
          end
        end
        S_SETTLE: begin
          if (r_wcnt == WIN_W'(3)) begin
            r_state <= S_COUNT;
            r_wcnt  <= '0;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        S_COUNT: begin
          if (r_wcnt == r_win - 1'b1) begin
            r_state <= S_COMPARE;
            r_ro_en <= 1'b0;
            r_wcnt  <= '0;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        S_COMPARE: begin
          r_resp[r_bit] <= (r_cnt[0] > r_cnt[1]);
`ifdef ROPUF_MARGIN_EN
          r_unst[r_bit] <= (w_diff < MARGIN_TH);
`endif
          if (r_bit == LAST_BIT) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_SETTLE;
            r_ro_en <= 1'b1;
            r_bit   <= r_bit + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ro_en    = r_ro_en;
  assign busy     = r_busy;
  assign done     = r_done;
  assign response = r_resp;
`ifdef ROPUF_MARGIN_EN
  assign unstable_mask = r_unst;
`endif

endmodule

// File: tb/tb_ro_puf_pair_comparator.sv
// Randomised bench for ro_puf_pair_comparator: square-wave oscillators, latency/handshake
// checks and a frequency-bound reference model of each response bit.
module tb_ro_puf_pair_comparator;

  localparam int N_RO   = 16;
  localparam int RESP_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_RO-1:0]   ro_in;
  logic              start;
  logic [3:0]        chal_a, chal_b;
  logic [15:0]       win_len;
  logic              ro_en, busy, done;
  logic [7:0]        response;
  logic              ro_en4, busy4, done4;
  logic [7:0]        response4;
`ifdef ROPUF_MARGIN_EN
  logic [7:0]        unstable_mask, unstable_mask4;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int t_cyc = 0;

  ro_puf_pair_comparator #(.N_RO(N_RO), .CNT_W(16), .WIN_W(16), .RESP_W(RESP_W)) u_dut (
    .clk(clk), .rst(rst), .ro_in(ro_in), .start(start), .chal_a(chal_a), .chal_b(chal_b),
    .win_len(win_len), .ro_en(ro_en), .busy(busy), .done(done), .response(response)
`ifdef ROPUF_MARGIN_EN
    , .unstable_mask(unstable_mask)
`endif
  );

  // narrow-counter instance sharing all inputs, used for the saturation case
  ro_puf_pair_comparator #(.N_RO(N_RO), .CNT_W(4), .WIN_W(16), .RESP_W(RESP_W)) u_dut4 (
    .clk(clk), .rst(rst), .ro_in(ro_in), .start(start), .chal_a(chal_a), .chal_b(chal_b),
    .win_len(win_len), .ro_en(ro_en4), .busy(busy4), .done(done4), .response(response4)
`ifdef ROPUF_MARGIN_EN
    , .unstable_mask(unstable_mask4)
`endif
  );

  always #5 clk = ~clk;

  // oscillator i: period 4+2i clk cycles, 50% duty, changing away from the sampling edge
  always @(negedge clk) begin
    t_cyc = t_cyc + 1;
    for (int i = 0; i < N_RO; i++)
      ro_in[i] = ((t_cyc % (4 + 2 * i)) < (2 + i));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // A period-p wave has floor(W/p) or ceil(W/p) rising edges in any W-cycle window.
  // A bit is decided only when those ranges (after saturation at cap) cannot overlap wrongly.
  function automatic void model(input int ca, input int cb, input int w, input int cap,
                                output logic [7:0] e, output logic [7:0] m);
    int ia, ib, pa, pb, loa, hia, lob, hib;
    e = '0;
    m = '0;
    for (int k = 0; k < RESP_W; k++) begin
      ia = (ca + k) % N_RO;
      ib = (cb + k) % N_RO;
      if (ia == ib) begin
        m[k] = 1'b1;
      end else begin
        pa  = 4 + 2 * ia;
        pb  = 4 + 2 * ib;
        loa = (w / pa > cap) ? cap : w / pa;
        hia = ((w + pa - 1) / pa > cap) ? cap : (w + pa - 1) / pa;
        lob = (w / pb > cap) ? cap : w / pb;
        hib = ((w + pb - 1) / pb > cap) ? cap : (w + pb - 1) / pb;
        if (loa > hib) begin
          e[k] = 1'b1;
          m[k] = 1'b1;
        end else if (hia <= lob) begin
          m[k] = 1'b1;
        end
      end
    end
  endfunction

  // One full run. intrude: pulse start with different inputs while busy.
  task automatic run(input string tag, input logic [3:0] ca, input logic [3:0] cb,
                     input logic [15:0] w, input bit intrude,
                     output logic [7:0] r, output logic [7:0] r4);
    int weff, lat, limit, n;
    bit got;
    logic [7:0] e, m, e4, m4;
    weff  = (w == 0) ? 1 : int'(w);
    lat   = RESP_W * (weff + 5) + 1;
    limit = lat + 50;
    got   = 1'b0;
    r     = '0;
    r4    = '0;
    @(negedge clk);
    chal_a = ca; chal_b = cb; win_len = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
    chk({tag, " ro_en_settle"}, {31'd0, ro_en}, 32'd1);
    chal_a = 4'($urandom); chal_b = 4'($urandom); win_len = 16'($urandom_range(0, 300));
    n = 0;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk); #1;
      if (intrude) start = (c == 30);
      if (done) begin
        n   = c;
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!got) begin
      chk({tag, " done_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, " latency"}, n, lat);
      chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
      r  = response;
      r4 = response4;
      model(ca, cb, weff, 65535, e, m);
      model(ca, cb, weff, 15, e4, m4);
      chk({tag, " resp"}, {24'd0, r & m}, {24'd0, e & m});
      chk({tag, " resp_cnt4"}, {24'd0, r4 & m4}, {24'd0, e4 & m4});
      @(posedge clk); #1;
      chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
      chk({tag, " resp_held"}, {24'd0, response}, {24'd0, r});
      $display("run %s: chal_a=%0d chal_b=%0d win=%0d lat=%0d resp=0x%02h resp4=0x%02h model=0x%02h/mask 0x%02h",
               tag, ca, cb, w, n, r, r4, e, m);
    end
  endtask

  initial begin
    logic [7:0] r, r4, r2;
    rst = 1'b1; start = 1'b0; chal_a = '0; chal_b = '0; win_len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset ro_en", {31'd0, ro_en}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset resp", {24'd0, response}, 32'd0);
    $display("reset: ro_en=%0b busy=%0b done=%0b resp=0x%02h", ro_en, busy, done, response);

    run("t2", 4'd0, 4'd1, 16'd100, 1'b0, r, r4);
    r2 = r;
    run("t2swap", 4'd1, 4'd0, 16'd100, 1'b0, r, r4);
    chk("t2swap zero", {24'd0, r}, 32'd0);
    run("t3", 4'd3, 4'd3, 16'd50, 1'b0, r, r4);
    chk("t3 tie", {24'd0, r}, 32'd0);
`ifdef ROPUF_MARGIN_EN
    chk("t3 unstable", {24'd0, unstable_mask}, 32'hFF);
`endif
    run("t4wrap", 4'd14, 4'd2, 16'd100, 1'b0, r, r4);
    chk("t4 wrap", {24'd0, r}, 32'hFC);
    run("t5sat", 4'd0, 4'd1, 16'd200, 1'b0, r, r4);
    chk("t5 sat low bits", {24'd0, r4 & 8'h0F}, 32'd0);
    run("t6intrude", 4'd0, 4'd1, 16'd100, 1'b1, r, r4);

    // abort mid-COUNT of the first bit
    @(negedge clk);
    chal_a = 4'd0; chal_b = 4'd1; win_len = 16'd100; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("abort ro_en", {31'd0, ro_en}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort resp", {24'd0, response}, 32'd0);
    $display("abort: ro_en=%0b busy=%0b resp=0x%02h", ro_en, busy, response);
    rst = 1'b0;
    run("t6fresh", 4'd0, 4'd1, 16'd100, 1'b0, r, r4);
    chk("t6 same low bits", {24'd0, r & 8'h0F}, {24'd0, r2 & 8'h0F});

    run("win0", 4'($urandom), 4'($urandom), 16'd0, 1'b0, r, r4);
    for (int i = 0; i < 4; i++)
      run("rand", 4'($urandom), 4'($urandom), 16'($urandom_range(150, 400)), 1'b0, r, r4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
